regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register_file write port between two writeback sources: ALU results and
//   load (MEM) results, each with a valid/ready handshake. Round-robin arbitration, with the
//   write port driven from a registered stage. Keeps a per-register pending-write scoreboard,
//   which drives a decode-stage hazard stall. Sits between EX/MEM writeback and register_file.
// PARAMETERS
//   XLEN      32  data width of the write port
//   ADDR_W     5  register address width
//   NUM_REGS  32  architectural registers; x0 is hardwired zero
//   MEM_FIRST  1  grant preference after reset: 1 = MEM first, 0 = ALU first
// PORTS
//   clk              in   1         rising-edge clock
//   reset_n          in   1         asynchronous reset, active-low
//   issue_valid      in   1         decode issues an instruction that writes issue_rd
//   issue_rd         in   ADDR_W    destination register of the issued instruction
//   alu_valid        in   1         ALU writeback request
//   alu_ready        out  1         ALU request accepted this cycle
//   alu_rd           in   ADDR_W    ALU destination register
//   alu_data         in   XLEN      ALU result
//   mem_valid        in   1         MEM writeback request
//   mem_ready        out  1         MEM request accepted this cycle
//   mem_rd           in   ADDR_W    MEM destination register
//   mem_data         in   XLEN      load result
//   rf_write_enable  out  1         to register_file.write_enable
//   rf_write_addr    out  ADDR_W    to register_file.write_addr
//   rf_write_data    out  XLEN      to register_file.write_data
//   chk_rs1, chk_rs2 in   ADDR_W    decode source registers to hazard-check
//   stall            out  1         decode must hold: a source register has a pending write
//   busy_mask        out  NUM_REGS  scoreboard, bit i = write to xi is outstanding
// BEHAVIOUR
//   Reset (async, reset_n=0): rf_write_enable/addr/data = 0, busy_mask = 0.
//     Pointer pref = MEM_FIRST. Any in-flight request is dropped.
//   Arbitration (combinational ready): at most one grant per cycle.
//     - Only one source valid: that source is granted.
//     - Both valid: the source named by pref is granted; pref then flips to the other source.
//     - Single-source grants leave pref unchanged.
//     - ready is never asserted without its own valid.
//     - A source holds valid/rd/data stable until its ready is seen.
//   Write stage: latency exactly 1 cycle.
//     - The handshake cycle loads rf_write_addr/data on the next edge.
//     - rf_write_enable=1 for exactly that one following cycle, unless rd==0.
//     - With no grant, rf_write_enable=0 next cycle. Addr and data hold their last value.
//     - rd==0 requests are still handshaken (ready=1) but produce rf_write_enable=0.
//   Scoreboard (updated on clock edge):
//     - Set: issue_valid with issue_rd!=0 sets busy[issue_rd].
//     - Clear: a granted handshake with rd!=0 clears busy[rd] on the same edge that loads the
//       write stage. During the rf write cycle the bit is already 0, and register_file
//       write-forwarding supplies the value.
//     - Set and clear of the same rd in one cycle: set wins (a newer writer is in flight).
//     - busy[0] is constant 0.
//     - A handshake to a non-busy rd is legal; clearing an already-clear bit is a no-op.
//   stall (combinational) = (chk_rs1!=0 & busy[chk_rs1]) | (chk_rs2!=0 & busy[chk_rs2]).
//     It reflects only current busy_mask, not same-cycle issue_valid.
// TESTING
//   1 reset_n=0 mid-write (rf_write_enable=1, busy=0x4)
//       -> all outputs 0 immediately; busy_mask=0.
//   2 issue rd=5; next cycle alu_valid rd=5 data=0x12345678
//       -> alu_ready=1 same cycle; next cycle rf_write_enable=1, addr=5, data=0x12345678;
//          busy[5] 1->0 on the handshake edge; stall (rs1=5) 1->0.
//   3 after reset, alu_valid and mem_valid both held 4 cycles, each dropping valid after ready
//       -> grants MEM, ALU; then idle; each produces exactly one rf write.
//   4 mem_valid rd=0 data=0xDEADBEEF -> mem_ready=1; rf_write_enable stays 0.
//   5 issue rd=3 in the same cycle an ALU rd=3 handshake completes -> busy[3]=1 afterwards.
//   6 chk_rs1=0, chk_rs2=7 with busy[7]=1 -> stall=1; clear x7 -> stall=0 the next cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bundle: ALU/MEM writeback handshakes, decode issue/hazard-check signals and
// the register_file write port.
interface regfile_wb_arbiter_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
);
    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_rd;
    logic                alu_valid;
    logic                alu_ready;
    logic [ADDR_W-1:0]   alu_rd;
    logic [XLEN-1:0]     alu_data;
    logic                mem_valid;
    logic                mem_ready;
    logic [ADDR_W-1:0]   mem_rd;
    logic [XLEN-1:0]     mem_data;
    logic                rf_write_enable;
    logic [ADDR_W-1:0]   rf_write_addr;
    logic [XLEN-1:0]     rf_write_data;
    logic [ADDR_W-1:0]   chk_rs1;
    logic [ADDR_W-1:0]   chk_rs2;
    logic                stall;
    logic [NUM_REGS-1:0] busy_mask;

    // Arbiter side
    modport slave (
        input  issue_valid, issue_rd,
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  chk_rs1, chk_rs2,
        output alu_ready, mem_ready,
        output rf_write_enable, rf_write_addr, rf_write_data,
        output stall, busy_mask
    );

    // Pipeline / register_file side
    modport master (
        output issue_valid, issue_rd,
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output chk_rs1, chk_rs2,
        input  alu_ready, mem_ready,
        input  rf_write_enable, rf_write_addr, rf_write_data,
        input  stall, busy_mask
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register_file write port between ALU and MEM writeback,
// with a registered write stage and a pending-write scoreboard driving the decode stall.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned NUM_REGS  = 32,
    parameter bit          MEM_FIRST = 1'b1
) (
    input logic                clk,
    input logic                reset_n,
    regfile_wb_arbiter_if.slave bus
);

    logic                grant_alu;
    logic                grant_mem;
    logic                granted;
    logic [ADDR_W-1:0]   grant_rd;
    logic [XLEN-1:0]     grant_data;

    logic                pref_mem_q, pref_mem_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     data_q, data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    always_comb begin
        grant_mem  = bus.mem_valid & (~bus.alu_valid | pref_mem_q);
        grant_alu  = bus.alu_valid & ~grant_mem;
        granted    = grant_alu | grant_mem;
        grant_rd   = grant_mem ? bus.mem_rd   : bus.alu_rd;
        grant_data = grant_mem ? bus.mem_data : bus.alu_data;

        // Preference only rotates when both sources actually contended
        pref_mem_d = (bus.alu_valid & bus.mem_valid) ? ~pref_mem_q : pref_mem_q;

        we_d   = granted & (grant_rd != '0);
        addr_d = addr_q;
        data_d = data_q;
        if (granted) begin
            addr_d = grant_rd;
            data_d = grant_data;
        end

        // Set is applied after clear so a newer in-flight writer wins
        busy_d = busy_q;
        if (we_d) busy_d[grant_rd] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != '0) busy_d[bus.issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pref_mem_q <= MEM_FIRST;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= '0;
        end else begin
            pref_mem_q <= pref_mem_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.alu_ready       = grant_alu;
    assign bus.mem_ready       = grant_mem;
    assign bus.rf_write_enable = we_q;
    assign bus.rf_write_addr   = addr_q;
    assign bus.rf_write_data   = data_q;
    assign bus.busy_mask       = busy_q;
    assign bus.stall           = ((bus.chk_rs1 != '0) & busy_q[bus.chk_rs1]) |
                                 ((bus.chk_rs2 != '0) & busy_q[bus.chk_rs2]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of grants, the write stage and the scoreboard.
module tb_regfile_wb_arbiter;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam bit          MEM_FIRST = 1'b1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    regfile_wb_arbiter_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) bus ();

    regfile_wb_arbiter #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .MEM_FIRST(MEM_FIRST)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit                  m_pref_mem;
    logic [NUM_REGS-1:0] m_busy;
    bit                  m_we;
    logic [ADDR_W-1:0]   m_addr;
    logic [XLEN-1:0]     m_data;
    bit                  g_alu, g_mem;

    function automatic void model_reset();
        m_pref_mem = MEM_FIRST;
        m_busy = '0;
        m_we = 1'b0;
        m_addr = '0;
        m_data = '0;
        g_alu = 1'b0;
        g_mem = 1'b0;
    endfunction

    function automatic void model_grant();
        g_alu = 1'b0;
        g_mem = 1'b0;
        if (bus.alu_valid && bus.mem_valid) begin
            if (m_pref_mem) g_mem = 1'b1;
            else            g_alu = 1'b1;
        end else if (bus.alu_valid) g_alu = 1'b1;
        else if (bus.mem_valid)     g_mem = 1'b1;
    endfunction

    function automatic bit model_stall();
        int r1 = int'(bus.chk_rs1);
        int r2 = int'(bus.chk_rs2);
        return (r1 != 0 && m_busy[r1]) || (r2 != 0 && m_busy[r2]);
    endfunction

    // Advance one clock edge, applying the spec rules to the model with the inputs seen there
    task automatic tick();
        int rd;
        model_grant();
        @(posedge clk);
        if (bus.alu_valid && bus.mem_valid) m_pref_mem = !m_pref_mem;
        m_we = 1'b0;
        if (g_alu || g_mem) begin
            rd     = g_mem ? int'(bus.mem_rd) : int'(bus.alu_rd);
            m_addr = ADDR_W'(rd);
            m_data = g_mem ? bus.mem_data : bus.alu_data;
            m_we   = (rd != 0);
            if (rd != 0) m_busy[rd] = 1'b0;
        end
        if (bus.issue_valid && bus.issue_rd != 0) m_busy[int'(bus.issue_rd)] = 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        bus.issue_valid = 1'b0; bus.issue_rd = '0;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.chk_rs1 = '0; bus.chk_rs2 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data, bus.busy_mask} !== '0)
            begin
            miscompares++;
            $display("FAIL reset_state: got we=%0b addr=%0d data=%h busy=%h, want all 0",
                     bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data, bus.busy_mask);
        end
        reset_n = 1'b1;
        // Build a write in flight with busy=0x4, then reset mid-write
        @(negedge clk);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd2; bus.chk_rs1 = 5'd2;
        tick();
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA5A5_0001;
        tick();
        vectors++;
        if (bus.rf_write_enable !== 1'b1 || bus.busy_mask !== 32'h4) begin
            miscompares++;
            $display("FAIL pre_reset_write: got we=%0b busy=%h, want we=1 busy=00000004",
                     bus.rf_write_enable, bus.busy_mask);
        end
        bus.alu_valid = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data, bus.busy_mask,
             bus.stall} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got we=%0b addr=%0d data=%h busy=%h stall=%0b, want 0",
                     bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data,
                     bus.busy_mask, bus.stall);
        end
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;
    endtask

    task automatic test_alu_write();
        @(negedge clk);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.chk_rs1 = 5'd5;
        tick();
        vectors++;
        if (bus.busy_mask[5] !== 1'b1 || bus.stall !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_issue: got busy5=%0b stall=%0b, want 1 1",
                     bus.busy_mask[5], bus.stall);
        end
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234_5678;
        #1;
        vectors++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0 || bus.stall !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_handshake: got alu_rdy=%0b mem_rdy=%0b stall=%0b, want 1 0 1",
                     bus.alu_ready, bus.mem_ready, bus.stall);
        end
        tick();
        vectors++;
        if (bus.rf_write_enable !== 1'b1 || bus.rf_write_addr !== 5'd5 ||
            bus.rf_write_data !== 32'h1234_5678 || bus.busy_mask[5] !== 1'b0 ||
            bus.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_write: got we=%0b addr=%0d data=%h busy5=%0b stall=%0b, %s",
                     bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data,
                     bus.busy_mask[5], bus.stall, "want 1 5 12345678 0 0");
        end
        @(negedge clk);
        idle_inputs();
        tick();
        vectors++;
        if (bus.rf_write_enable !== 1'b0 || bus.rf_write_data !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL alu_write_end: got we=%0b data=%h, want 0 12345678 (held)",
                     bus.rf_write_enable, bus.rf_write_data);
        end
    endtask

    task automatic test_both_contend();
        int writes = 0;
        do_reset();
        @(negedge clk);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = $urandom;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd11; bus.mem_data = $urandom;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (g_alu) bus.alu_valid = 1'b0;
                if (g_mem) bus.mem_valid = 1'b0;
            end
            #1;
            model_grant();
            vectors++;
            if (bus.mem_ready !== (i == 0) || bus.alu_ready !== (i == 1)) begin
                miscompares++;
                $display("FAIL contend_grant[%0d]: got mem_rdy=%0b alu_rdy=%0b, want %0b %0b",
                         i, bus.mem_ready, bus.alu_ready, i == 0, i == 1);
            end
            tick();
            if (bus.rf_write_enable === 1'b1) writes++;
            vectors++;
            if (bus.rf_write_enable !== m_we || bus.rf_write_addr !== m_addr ||
                bus.rf_write_data !== m_data) begin
                miscompares++;
                $display("FAIL contend_write[%0d]: got we=%0b addr=%0d data=%h, want %0b %0d %h",
                         i, bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data,
                         m_we, m_addr, m_data);
            end
        end
        vectors++;
        if (writes != 2) begin
            miscompares++;
            $display("FAIL contend_count: got %0d rf writes, want 2", writes);
        end
    endtask

    task automatic test_rd_zero();
        @(negedge clk);
        idle_inputs();
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (bus.mem_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rd0_ready: got mem_rdy=%0b, want 1", bus.mem_ready);
        end
        tick();
        vectors++;
        if (bus.rf_write_enable !== 1'b0 || bus.busy_mask[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL rd0_write: got we=%0b busy0=%0b, want 0 0",
                     bus.rf_write_enable, bus.busy_mask[0]);
        end
        @(negedge clk);
        idle_inputs();
        tick();
    endtask

    task automatic test_set_wins();
        @(negedge clk);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        tick();
        @(negedge clk);
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_0333;
        tick();
        vectors++;
        if (bus.busy_mask[3] !== 1'b1 || bus.rf_write_enable !== 1'b1 ||
            bus.rf_write_addr !== 5'd3) begin
            miscompares++;
            $display("FAIL set_wins: got busy3=%0b we=%0b addr=%0d, want 1 1 3",
                     bus.busy_mask[3], bus.rf_write_enable, bus.rf_write_addr);
        end
        @(negedge clk);
        idle_inputs();
        tick();
    endtask

    task automatic test_stall();
        @(negedge clk);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        tick();
        @(negedge clk);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd7;
        #1;
        vectors++;
        if (bus.stall !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_rs2: got stall=%0b, want 1", bus.stall);
        end
        bus.chk_rs2 = 5'd9;
        #1;
        vectors++;
        if (bus.stall !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_same_cycle_issue: got stall=%0b, want 0", bus.stall);
        end
        bus.chk_rs2 = 5'd7;
        tick();
        @(negedge clk);
        bus.issue_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h7777_7777;
        tick();
        vectors++;
        if (bus.stall !== 1'b0 || bus.busy_mask !== m_busy) begin
            miscompares++;
            $display("FAIL stall_clear: got stall=%0b busy=%h, want 0 %h",
                     bus.stall, bus.busy_mask, m_busy);
        end
        @(negedge clk);
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (g_alu) bus.alu_valid = 1'b0;
            if (g_mem) bus.mem_valid = 1'b0;
            if (!bus.alu_valid && $urandom_range(0, 1) == 1) begin
                bus.alu_valid = 1'b1;
                bus.alu_rd = ADDR_W'($urandom_range(0, NUM_REGS - 1));
                bus.alu_data = $urandom;
            end
            if (!bus.mem_valid && $urandom_range(0, 1) == 1) begin
                bus.mem_valid = 1'b1;
                bus.mem_rd = ADDR_W'($urandom_range(0, NUM_REGS - 1));
                bus.mem_data = $urandom;
            end
            bus.issue_valid = ($urandom_range(0, 2) == 0);
            bus.issue_rd = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            bus.chk_rs1 = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            bus.chk_rs2 = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            #1;
            model_grant();
            vectors++;
            if (bus.alu_ready !== g_alu || bus.mem_ready !== g_mem ||
                bus.stall !== model_stall()) begin
                miscompares++;
                $display("FAIL rand_comb[%0d]: got alu=%0b mem=%0b stall=%0b, want %0b %0b %0b",
                         i, bus.alu_ready, bus.mem_ready, bus.stall,
                         g_alu, g_mem, model_stall());
            end
            tick();
            vectors++;
            if (bus.rf_write_enable !== m_we || bus.rf_write_addr !== m_addr ||
                bus.rf_write_data !== m_data || bus.busy_mask !== m_busy) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: got %0b %0d %h %h, want %0b %0d %h %h", i,
                         bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data,
                         bus.busy_mask, m_we, m_addr, m_data, m_busy);
            end
        end
        @(negedge clk);
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_both_contend();
        test_rd_zero();
        test_set_wins();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
